ddr_amm_responder: RTL and testbench
====================================

# ddr_amm_responder

Avalon-MM responder modelling the DDR EMIF user port: it accepts the 256-bit burst read/write traffic issued by the DDR setup master and backs it with a small on-chip word memory. It also generates the calibration status pair after reset. It sits on the `avalon_clk` domain and lets the setup/test master run in simulation and in board builds without the external memory controller.

## Interface
- `MEM_AW`, 10: implemented word-address bits; memory depth is 2^MEM_AW words of 256 bits.
- `READ_LATENCY`, 4: cycles from read command acceptance to the first `amm_readdatavalid`; legal range 1..15.
- `CAL_CYCLES`, 64: cycles after reset release before calibration status asserts; legal range 1..65535.
- `FAIL_CAL`, 0: 1 = report `local_cal_fail` instead of success.

Ports:
- `avalon_clk` in 1: single clock.
- `avalon_reset` in 1: synchronous, active-high reset.
- `amm_addr` in 25: word address, sampled on the first beat of a burst only.
- `amm_read` in 1: read command.
- `amm_write` in 1: write beat.
- `amm_writedata` in 256: write data.
- `amm_byteenable` in 32: per-byte write enable.
- `amm_burstcount` in 7: beats in the burst, sampled on the first beat; 0 is treated as 1.
- `amm_ready` out 1: high = command/beat accepted this cycle (inverse waitrequest).
- `amm_readdata` out 256: read data.
- `amm_readdatavalid` out 1: `amm_readdata` valid this cycle.
- `local_cal_success` out 1: calibration passed.
- `local_cal_fail` out 1: calibration failed.

## Operation
- States: CAL, IDLE, WR_BURST, RD_WAIT, RD_BURST, FAILED.
- **CAL**
  - A 16-bit counter counts to `CAL_CYCLES`.
  - With `FAIL_CAL`=0, go to IDLE and set `local_cal_success`=1 (sticky until reset).
  - With `FAIL_CAL`=1, go to FAILED and set `local_cal_fail`=1.
  - `amm_ready`=0 throughout.
- **FAILED**: `amm_ready` stays 0 until reset.
- **IDLE**: `amm_ready`=1.
  - `amm_write` accepted: write beat 0 to `amm_addr[MEM_AW-1:0]`, honouring `amm_byteenable`, and latch the beat count.
    - If beat count > 1, go to WR_BURST with remaining = count-1 and next address = addr+1.
    - Otherwise stay in IDLE.
  - `amm_read` accepted without `amm_write`: latch address and count, go to RD_WAIT.
  - `amm_read` and `amm_write` together: the write wins and the read is dropped.
- **WR_BURST**: `amm_ready`=1.
  - Each `amm_write` cycle writes one beat at the running address; address increments and remaining decrements.
  - Cycles without `amm_write` are idle and do not advance the burst.
  - `amm_read` is ignored.
  - Return to IDLE in the cycle the last beat is accepted.
- **RD_WAIT**: latency counter runs, then go to RD_BURST.
- **RD_BURST**: one beat per consecutive cycle, address incrementing; return to IDLE after the last beat.
- Address arithmetic:
  - The running address is `MEM_AW` bits and wraps modulo 2^MEM_AW.
  - `amm_addr` bits above `MEM_AW` are ignored (aliasing).
- Memory contents are zero at configuration and are not cleared by reset.
- Byte lane i covers `writedata[8i+7:8i]` and is written only when `byteenable[i]`=1.

## Timing
- Reset values: `amm_ready`=0, `amm_readdatavalid`=0, `amm_readdata`=0, `local_cal_success`=0, `local_cal_fail`=0; state CAL, counters 0.
- Calibration: with reset deasserted at cycle R, the status output rises at cycle R+`CAL_CYCLES`. `amm_ready` rises in that same cycle when calibration passes.
- Read accepted at cycle T:
  - `amm_ready`=0 from T+1.
  - `amm_readdatavalid`=1 on cycles T+`READ_LATENCY` … T+`READ_LATENCY`+N-1, with no gaps.
  - `amm_ready`=1 again at T+`READ_LATENCY`+N.
  - Reads never overlap: one outstanding burst.
- `amm_readdata` holds its last value when `amm_readdatavalid`=0.
- Write data is readable by a read command accepted the cycle after the last write beat (read-after-write hazard-free).
- Reset mid-burst: next cycle all outputs take reset values, any in-flight read beats are discarded, and calibration restarts.

## Test plan
- Calibration: `CAL_CYCLES`=64, release reset -> `local_cal_success` and `amm_ready` rise exactly 64 cycles later; `local_cal_fail` stays 0. With `FAIL_CAL`=1 -> `local_cal_fail` rises at 64 and `amm_ready` stays 0 for 1000 cycles.
- Single write/read: write 0xA5 pattern to addr 5 with all byteenables, then read addr 5 with burst 1 -> one valid beat of the pattern at T+4; `amm_ready` low T+1..T+4 and high at T+5.
- Burst with gaps: 8-beat write at addr 0x10 with `amm_write` deasserted for 3 cycles mid-burst, then 8-beat read -> 8 consecutive valid beats matching in order.
- Byte enables: write all-ones, then write zeros with `byteenable`=0x0000_000F -> readback has low 4 bytes 0 and the rest 0xFF.
- Wrap/alias: `MEM_AW`=10, 4-beat write at addr 0x3FE -> beats land at 0x3FE, 0x3FF, 0x000, 0x001; a read of addr 0x400 returns the word at 0x000.
- Reset mid-read: assert reset during beat 3 of a 16-beat read -> `amm_readdatavalid`=0 the next cycle with no further beats; calibration re-runs; memory data is preserved on a later read.

Source files
------------

// File: rtl/ddr_amm_responder.sv
// Avalon-MM stand-in for the DDR EMIF user port: burst reads/writes backed by an on-chip
// 256-bit word memory, plus the post-reset calibration status pair.
module ddr_amm_responder #(
  parameter int unsigned MEM_AW       = 10,
  parameter int unsigned READ_LATENCY = 4,
  parameter int unsigned CAL_CYCLES   = 64,
  parameter bit          FAIL_CAL     = 1'b0
) (
  input  logic         avalon_clk,
  input  logic         avalon_reset,
  input  logic [24:0]  amm_addr,
  input  logic         amm_read,
  input  logic         amm_write,
  input  logic [255:0] amm_writedata,
  input  logic [31:0]  amm_byteenable,
  input  logic [6:0]   amm_burstcount,
  output logic         amm_ready,
  output logic [255:0] amm_readdata,
  output logic         amm_readdatavalid,
  output logic         local_cal_success,
  output logic         local_cal_fail
);

  localparam int unsigned Depth = 2 ** MEM_AW;

  typedef enum logic [2:0] {StCal, StIdle, StWrBurst, StRdWait, StRdBurst, StFailed} state_e;

  state_e            state_q, state_d;
  logic [15:0]       cal_cnt_q, cal_cnt_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [6:0]        rem_q, rem_d;
  logic              cal_success_q, cal_success_d;
  logic              cal_fail_q, cal_fail_d;
  logic              rvalid_q;
  logic [255:0]      rdata_q;
  logic [255:0]      mem [Depth];

  logic              wr_en, rd_en;
  logic [MEM_AW-1:0] wr_addr, rd_addr, cmd_addr;
  logic [6:0]        beats;
  logic              unused_addr;

  assign cmd_addr    = amm_addr[MEM_AW-1:0];
  assign unused_addr = ^amm_addr[24:MEM_AW];
  assign beats       = (amm_burstcount == 7'd0) ? 7'd1 : amm_burstcount;

  // Holding ready low while the last read beat is on the bus keeps reads non-overlapping.
  assign amm_ready = (state_q == StIdle || state_q == StWrBurst) && !rvalid_q;

  always_comb begin
    state_d       = state_q;
    cal_cnt_d     = cal_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    cal_success_d = cal_success_q;
    cal_fail_d    = cal_fail_q;
    wr_en         = 1'b0;
    wr_addr       = addr_q;
    rd_en         = 1'b0;
    rd_addr       = addr_q;
    unique case (state_q)
      StCal: begin
        if (cal_cnt_q == 16'(CAL_CYCLES - 1)) begin
          if (FAIL_CAL) begin
            state_d    = StFailed;
            cal_fail_d = 1'b1;
          end else begin
            state_d       = StIdle;
            cal_success_d = 1'b1;
          end
        end else begin
          cal_cnt_d = cal_cnt_q + 16'd1;
        end
      end
      StIdle: begin
        if (amm_ready && amm_write) begin
          wr_en   = 1'b1;
          wr_addr = cmd_addr;
          addr_d  = cmd_addr + MEM_AW'(1);
          rem_d   = beats - 7'd1;
          if (beats > 7'd1) state_d = StWrBurst;
        end else if (amm_ready && amm_read) begin
          lat_cnt_d = '0;
          if (READ_LATENCY == 1) begin
            // Beat 0 must be fetched on the accepting edge to appear one cycle later.
            rd_en   = 1'b1;
            rd_addr = cmd_addr;
            addr_d  = cmd_addr + MEM_AW'(1);
            rem_d   = beats - 7'd1;
            if (beats > 7'd1) state_d = StRdBurst;
          end else begin
            addr_d  = cmd_addr;
            rem_d   = beats;
            state_d = (READ_LATENCY == 2) ? StRdBurst : StRdWait;
          end
        end
      end
      StWrBurst: begin
        if (amm_write) begin
          wr_en  = 1'b1;
          addr_d = addr_q + MEM_AW'(1);
          rem_d  = rem_q - 7'd1;
          if (rem_q == 7'd1) state_d = StIdle;
        end
      end
      StRdWait: begin
        if (lat_cnt_q == 4'(READ_LATENCY - 3)) state_d = StRdBurst;
        else lat_cnt_d = lat_cnt_q + 4'd1;
      end
      StRdBurst: begin
        rd_en  = 1'b1;
        addr_d = addr_q + MEM_AW'(1);
        rem_d  = rem_q - 7'd1;
        if (rem_q == 7'd1) state_d = StIdle;
      end
      StFailed: state_d = StFailed;
      default:  state_d = StCal;
    endcase
  end

  always_ff @(posedge avalon_clk) begin
    if (avalon_reset) begin
      state_q       <= StCal;
      cal_cnt_q     <= '0;
      lat_cnt_q     <= '0;
      addr_q        <= '0;
      rem_q         <= '0;
      cal_success_q <= 1'b0;
      cal_fail_q    <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      cal_cnt_q     <= cal_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
      addr_q        <= addr_d;
      rem_q         <= rem_d;
      cal_success_q <= cal_success_d;
      cal_fail_q    <= cal_fail_d;
      rvalid_q      <= rd_en;
      if (rd_en) rdata_q <= mem[rd_addr];
    end
  end

  // Storage is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge avalon_clk) begin
    if (wr_en && !avalon_reset) begin
      for (int i = 0; i < 32; i++) begin
        if (amm_byteenable[i]) mem[wr_addr][8*i +: 8] <= amm_writedata[8*i +: 8];
      end
    end
  end

  assign amm_readdata      = rdata_q;
  assign amm_readdatavalid = rvalid_q;
  assign local_cal_success = cal_success_q;
  assign local_cal_fail    = cal_fail_q;

endmodule

// File: tb/tb_ddr_amm_responder.sv
// Directed + randomized bench for ddr_amm_responder against a word-array reference model.
module tb_ddr_amm_responder;

  localparam int LAT   = 4;
  localparam int CAL   = 64;
  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic [24:0]  amm_addr;
  logic         amm_read, amm_write;
  logic [255:0] amm_writedata;
  logic [31:0]  amm_byteenable;
  logic [6:0]   amm_burstcount;
  logic         amm_ready, amm_readdatavalid, local_cal_success, local_cal_fail;
  logic [255:0] amm_readdata;
  logic         ready2, valid2, success2, fail2;
  logic [255:0] readdata2;

  int           checks = 0;
  int           errors = 0;
  logic [255:0] model [DEPTH];
  logic [255:0] last_rd;

  always #5 clk = ~clk;

  ddr_amm_responder #(.MEM_AW(10), .READ_LATENCY(LAT), .CAL_CYCLES(CAL), .FAIL_CAL(1'b0)) dut (
    .avalon_clk(clk), .avalon_reset(rst), .amm_addr(amm_addr), .amm_read(amm_read),
    .amm_write(amm_write), .amm_writedata(amm_writedata), .amm_byteenable(amm_byteenable),
    .amm_burstcount(amm_burstcount), .amm_ready(amm_ready), .amm_readdata(amm_readdata),
    .amm_readdatavalid(amm_readdatavalid), .local_cal_success(local_cal_success),
    .local_cal_fail(local_cal_fail)
  );

  ddr_amm_responder #(.MEM_AW(10), .READ_LATENCY(LAT), .CAL_CYCLES(CAL), .FAIL_CAL(1'b1)) dut_fail (
    .avalon_clk(clk), .avalon_reset(rst), .amm_addr(amm_addr), .amm_read(amm_read),
    .amm_write(amm_write), .amm_writedata(amm_writedata), .amm_byteenable(amm_byteenable),
    .amm_burstcount(amm_burstcount), .amm_ready(ready2), .amm_readdata(readdata2),
    .amm_readdatavalid(valid2), .local_cal_success(success2), .local_cal_fail(fail2)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] gen_data(input int mode);
    logic [255:0] d;
    case (mode)
      1:       d = '1;
      2:       d = '0;
      3:       d = {32{8'hA5}};
      default: for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom;
    endcase
    return d;
  endfunction

  task automatic model_write(input int idx, input logic [255:0] d, input logic [31:0] be);
    for (int b = 0; b < 32; b++) if (be[b]) model[idx][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic wait_ready();
    int c = 0;
    while (amm_ready !== 1'b1 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (c == 200) chk("ready_timeout", amm_ready, 1'b1);
  endtask

  // Release reset and confirm the status pair rises exactly CAL edges later.
  task automatic release_and_cal();
    bit seen_valid = 1'b0;
    rst = 1'b0;
    for (int c = 1; c <= CAL; c++) begin
      @(negedge clk);
      if (amm_readdatavalid !== 1'b0) seen_valid = 1'b1;
      if (c == CAL - 1) begin
        chk("cal_success_early", local_cal_success, 1'b0);
        chk("cal_ready_early", amm_ready, 1'b0);
        chk("calfail_early", fail2, 1'b0);
      end
    end
    chk("cal_success", local_cal_success, 1'b1);
    chk("cal_ready", amm_ready, 1'b1);
    chk("cal_fail_low", local_cal_fail, 1'b0);
    chk("calfail_fail", fail2, 1'b1);
    chk("calfail_success_low", success2, 1'b0);
    chk("calfail_ready_low", ready2, 1'b0);
    chk("cal_no_valid", seen_valid, 1'b0);
  endtask

  task automatic wr_burst(input logic [24:0] addr, input logic [6:0] bc, input int gap_at,
                          input int gap_len, input logic [31:0] be, input int mode);
    int n;
    logic [255:0] d;
    n = (bc == 7'd0) ? 1 : int'(bc);
    wait_ready();
    for (int i = 0; i < n; i++) begin
      if (i > 0 && i == gap_at && gap_len > 0) begin
        amm_write = 1'b0;
        amm_read  = 1'b1;  // must be ignored mid-burst
        repeat (gap_len) @(negedge clk);
        amm_read  = 1'b0;
      end
      d              = gen_data(mode);
      amm_write      = 1'b1;
      amm_addr       = (i == 0) ? addr : 25'($urandom);
      amm_burstcount = (i == 0) ? bc : 7'($urandom);
      amm_writedata  = d;
      amm_byteenable = be;
      chk("wr_ready", amm_ready, 1'b1);
      model_write((int'(addr[9:0]) + i) % DEPTH, d, be);
      @(negedge clk);
    end
    amm_write = 1'b0;
    chk("wr_done_ready", amm_ready, 1'b1);
    chk("wr_done_novalid", amm_readdatavalid, 1'b0);
  endtask

  task automatic rd_burst(input logic [24:0] addr, input logic [6:0] bc);
    int n;
    n = (bc == 7'd0) ? 1 : int'(bc);
    wait_ready();
    amm_read       = 1'b1;
    amm_addr       = addr;
    amm_burstcount = bc;
    @(negedge clk);
    amm_read       = 1'b0;
    amm_addr       = 25'($urandom);
    amm_burstcount = 7'($urandom);
    for (int k = 1; k <= LAT + n; k++) begin
      bit v;
      v = (k >= LAT) && (k < LAT + n);
      chk("rd_valid", amm_readdatavalid, v);
      chk("rd_ready", amm_ready, k == LAT + n);
      if (v) last_rd = model[(int'(addr[9:0]) + k - LAT) % DEPTH];
      chk("rd_data", amm_readdata, last_rd);
      if (k < LAT + n) @(negedge clk);
    end
  endtask

  initial begin
    bit seen;
    logic [255:0] d;
    logic [24:0] a;
    int n;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    last_rd = '0;
    rst = 1'b1; amm_addr = '0; amm_read = 1'b0; amm_write = 1'b0;
    amm_writedata = '0; amm_byteenable = '0; amm_burstcount = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", amm_ready, 1'b0);
    chk("rst_valid", amm_readdatavalid, 1'b0);
    chk("rst_rdata", amm_readdata, '0);
    chk("rst_success", local_cal_success, 1'b0);
    chk("rst_fail", local_cal_fail, 1'b0);
    release_and_cal();

    // The failing instance must never raise ready.
    seen = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (ready2 !== 1'b0 || valid2 !== 1'b0) seen = 1'b1;
    end
    chk("calfail_ready_1000", seen, 1'b0);
    chk("calfail_rdata", readdata2, '0);

    // Single beat: pattern at address 5.
    wr_burst(25'd5, 7'd1, 0, 0, '1, 3);
    rd_burst(25'd5, 7'd1);
    chk("a5_pattern", amm_readdata, {32{8'hA5}});

    // 8-beat write with a 3-cycle stall, then 8-beat read.
    wr_burst(25'h10, 7'd8, 4, 3, '1, 0);
    rd_burst(25'h10, 7'd8);

    // Byte enables.
    wr_burst(25'h40, 7'd1, 0, 0, '1, 1);
    wr_burst(25'h40, 7'd1, 0, 0, 32'h0000_000F, 2);
    rd_burst(25'h40, 7'd1);
    chk("be_pattern", amm_readdata, {{28{8'hFF}}, 32'h0});

    // Wrap and alias.
    wr_burst(25'h3FE, 7'd4, 0, 0, '1, 0);
    rd_burst(25'h3FE, 7'd4);
    rd_burst(25'h400, 7'd1);

    // Simultaneous read and write: the read is dropped.
    wait_ready();
    a = 25'h123; d = gen_data(0);
    amm_write = 1'b1; amm_read = 1'b1; amm_addr = a; amm_burstcount = 7'd1;
    amm_writedata = d; amm_byteenable = '1;
    model_write(int'(a[9:0]), d, '1);
    @(negedge clk);
    amm_write = 1'b0; amm_read = 1'b0;
    seen = 1'b0;
    repeat (LAT + 2) begin
      if (amm_readdatavalid !== 1'b0 || amm_ready !== 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    chk("rw_read_dropped", seen, 1'b0);
    rd_burst(a, 7'd0);

    // Randomized bursts, including aliased high address bits.
    for (int it = 0; it < 6; it++) begin
      a = 25'($urandom);
      n = (it == 0) ? 0 : $urandom_range(1, 12);
      wr_burst(a, 7'(n), $urandom_range(1, 12), $urandom_range(0, 3), $urandom, 0);
      rd_burst(a, 7'(n));
    end

    // Reset during beat 3 of a 16-beat read.
    wr_burst(25'h80, 7'd16, 0, 0, '1, 0);
    wait_ready();
    amm_read = 1'b1; amm_addr = 25'h80; amm_burstcount = 7'd16;
    @(negedge clk);
    amm_read = 1'b0;
    for (int k = 1; k < LAT + 2; k++) @(negedge clk);
    chk("mid_beat3_valid", amm_readdatavalid, 1'b1);
    chk("mid_beat3_data", amm_readdata, model[16'h82]);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", amm_readdatavalid, 1'b0);
    chk("mid_rst_ready", amm_ready, 1'b0);
    chk("mid_rst_rdata", amm_readdata, '0);
    chk("mid_rst_success", local_cal_success, 1'b0);
    last_rd = '0;
    @(negedge clk);
    release_and_cal();
    rd_burst(25'h80, 7'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
